// File: rtl/serial_mode_unit_pkg.sv
// Shared mode codes, default width and controller state type for serial_mode_unit.
// Pure declarations: no logic, no latency, no flow control.
package serial_mode_unit_pkg;
    localparam int         WIDTH_DEF   = 8;
    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;
    localparam logic [1:0] MODE_ROTATE = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/serial_mode_unit_rise_detect.sv
// Rising-edge detector: start_edge is high in the cycle start goes 0->1, zero latency from start.
// No flow control; the history flop clears on synchronous reset.
module serial_mode_unit_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic start_edge
);
    logic start_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_d <= 1'b0;
        end else begin
            start_d <= start;
        end
    end

    assign start_edge = start & ~start_d;
endmodule

// File: rtl/serial_mode_unit.sv
// 8-bit data register with mode controller: load, MSB-first shift-out, or rotate, one step per cycle.
// Start is edge-triggered; on==00 aborts a running operation on the next edge; no backpressure.
module serial_mode_unit
    import serial_mode_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         x,
    input  logic [1:0]               on,
    input  logic                     start,
    output logic [WIDTH-1:0]         y,
    output logic [$clog2(WIDTH)-1:0] s,
    output logic                     b,
    output logic                     active,
    output logic [1:0]               regime
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] S_LAST = SW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic [SW-1:0]    s_nxt;
    logic             b_nxt;
    logic [1:0]       regime_nxt;
    logic             start_edge;

    serial_mode_unit_rise_detect u_rise (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_edge (start_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            y      <= '0;
            s      <= '0;
            b      <= 1'b0;
            regime <= MODE_IDLE;
        end else begin
            state  <= state_nxt;
            y      <= y_nxt;
            s      <= s_nxt;
            b      <= b_nxt;
            regime <= regime_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        y_nxt      = y;
        s_nxt      = s;
        b_nxt      = b;
        regime_nxt = regime;
        case (state)
            ST_IDLE: begin
                if (start_edge && (on != MODE_IDLE)) begin
                    state_nxt  = ST_RUN;
                    regime_nxt = on;
                    s_nxt      = '0;
                end
            end
            ST_RUN: begin
                // Abort wins over the step: y and b freeze at their current values.
                if (on == MODE_IDLE) begin
                    state_nxt  = ST_IDLE;
                    regime_nxt = MODE_IDLE;
                    s_nxt      = '0;
                end else begin
                    case (regime)
                        MODE_LOAD: begin
                            y_nxt      = x;
                            b_nxt      = 1'b0;
                            state_nxt  = ST_IDLE;
                            regime_nxt = MODE_IDLE;
                            s_nxt      = '0;
                        end
                        MODE_SHIFT, MODE_ROTATE: begin
                            b_nxt = y[WIDTH-1];
                            y_nxt = {y[WIDTH-2:0], (regime == MODE_ROTATE) ? y[WIDTH-1] : 1'b0};
                            s_nxt = s + 1'b1;
                            if (s == S_LAST) begin
                                state_nxt  = ST_IDLE;
                                regime_nxt = MODE_IDLE;
                            end
                        end
                        default: begin
                            state_nxt  = ST_IDLE;
                            regime_nxt = MODE_IDLE;
                            s_nxt      = '0;
                        end
                    endcase
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign active = (state == ST_RUN);
endmodule

// File: tb/tb_serial_mode_unit.sv
// Directed scenarios plus randomized traffic checked against an operation-level reference model.
module tb_serial_mode_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] x = '0;
    logic [1:0] on = '0;
    logic       start = 1'b0;
    logic [7:0] y;
    logic [2:0] s;
    logic       b;
    logic       active;
    logic [1:0] regime;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode as an int (0 = idle), step count as an int.
    logic [7:0] m_y = '0;
    int         m_s = 0;
    logic       m_b = 1'b0;
    int         m_mode = 0;
    logic       m_prev_start = 1'b0;

    serial_mode_unit dut (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .on     (on),
        .start  (start),
        .y      (y),
        .s      (s),
        .b      (b),
        .active (active),
        .regime (regime)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic edge_seen;
        if (rst) begin
            m_y = '0; m_s = 0; m_b = 1'b0; m_mode = 0; m_prev_start = 1'b0;
        end else begin
            edge_seen = start && !m_prev_start;
            m_prev_start = start;
            if (m_mode == 0) begin
                if (edge_seen && on != 2'b00) begin
                    m_mode = int'(on);
                    m_s = 0;
                end
            end else if (on == 2'b00) begin
                m_mode = 0;
                m_s = 0;
            end else if (m_mode == 2) begin
                m_y = x; m_b = 1'b0; m_mode = 0; m_s = 0;
            end else begin
                m_b = m_y[7];
                if (m_mode == 1) m_y = m_y * 2;
                else m_y = (m_y * 2) + (m_y / 128);
                if (m_s == 7) begin m_mode = 0; m_s = 0; end
                else m_s = m_s + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; x = 8'hA5; on = 2'b11; start = 1'b1;
        tick();
        vectors++;
        if ({y, s, b, active, regime} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset: got y=%h s=%0d b=%b act=%b reg=%b, want all zero", y, s, b, active, regime);
        end
        rst = 1'b0; start = 1'b0; on = 2'b00;
        tick();
    endtask

    task automatic load_value(input logic [7:0] val);
        start = 1'b0; on = 2'b10; x = val;
        tick();
        start = 1'b1;
        tick();
        vectors++;
        if (active !== 1'b1 || regime !== 2'b10 || s !== 3'd0) begin
            miscompares++;
            $display("FAIL load_start: got act=%b reg=%b s=%0d, want 1 10 0", active, regime, s);
        end
        tick();
        vectors++;
        if (y !== val || active !== 1'b0 || regime !== 2'b00 || b !== 1'b0) begin
            miscompares++;
            $display("FAIL load_done: got y=%h act=%b reg=%b b=%b, want y=%h 0 00 0", y, active, regime, b, val);
        end
        start = 1'b0;
    endtask

    task automatic test_load();
        load_value(8'h96);
    endtask

    task automatic run_serial(input logic [1:0] mode, input logic [7:0] init, input string name);
        logic [7:0] exp_y;
        logic       exp_bit;
        exp_y = init;
        start = 1'b0; on = mode;
        tick();
        start = 1'b1;
        tick();
        vectors++;
        if (active !== 1'b1 || regime !== mode || s !== 3'd0) begin
            miscompares++;
            $display("FAIL %s_start: got act=%b reg=%b s=%0d, want 1 %b 0", name, active, regime, s, mode);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (s !== 3'(k) || active !== 1'b1 || regime !== mode) begin
                miscompares++;
                $display("FAIL %s_step%0d: got s=%0d act=%b reg=%b, want s=%0d 1 %b", name, k, s, active, regime, k, mode);
            end
            exp_bit = init[7-k];
            exp_y = (mode == 2'b11) ? {exp_y[6:0], exp_y[7]} : {exp_y[6:0], 1'b0};
            tick();
            vectors++;
            if (b !== exp_bit || y !== exp_y) begin
                miscompares++;
                $display("FAIL %s_bit%0d: got b=%b y=%h, want b=%b y=%h", name, k, b, y, exp_bit, exp_y);
            end
        end
        vectors++;
        if (active !== 1'b0 || regime !== 2'b00 || s !== 3'd0) begin
            miscompares++;
            $display("FAIL %s_done: got act=%b reg=%b s=%0d, want 0 00 0", name, active, regime, s);
        end
        start = 1'b0;
    endtask

    task automatic test_shift();
        run_serial(2'b01, 8'h96, "shift");
        vectors++;
        if (y !== 8'h00) begin
            miscompares++;
            $display("FAIL shift_final: got y=%h, want 00", y);
        end
    endtask

    task automatic test_rotate();
        load_value(8'h1A);
        run_serial(2'b11, 8'h1A, "rotate");
        vectors++;
        if (y !== 8'h1A) begin
            miscompares++;
            $display("FAIL rotate_final: got y=%h, want 1a", y);
        end
    endtask

    task automatic test_abort_held_start();
        start = 1'b0; on = 2'b01;
        tick();
        start = 1'b1;
        tick();
        tick(); tick(); tick();
        on = 2'b00;
        tick();
        vectors++;
        if (active !== 1'b0 || regime !== 2'b00 || s !== 3'd0 || y !== 8'hD0 || b !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: got act=%b reg=%b s=%0d y=%h b=%b, want 0 00 0 d0 0", active, regime, s, y, b);
        end
        on = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (active !== 1'b0 || y !== 8'hD0) begin
                miscompares++;
                $display("FAIL held_start%0d: got act=%b y=%h, want 0 d0", k, active, y);
            end
        end
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        vectors++;
        if (active !== 1'b1 || regime !== 2'b01) begin
            miscompares++;
            $display("FAIL restart: got act=%b reg=%b, want 1 01", active, regime);
        end
        on = 2'b00;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        load_value(8'h5C);
        start = 1'b0; on = 2'b11;
        tick();
        start = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({y, s, b, active, regime} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got y=%h s=%0d b=%b act=%b reg=%b, want all zero", y, s, b, active, regime);
        end
        rst = 1'b0;
        tick(); tick();
        vectors++;
        if (active !== 1'b1 || y !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_after: got act=%b y=%h, want 1 00 (held start re-edges after reset)", active, y);
        end
        start = 1'b0; on = 2'b00;
        tick();
    endtask

    task automatic test_random();
        logic [14:0] exp;
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            on    = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            start = ($urandom_range(0, 3) == 0);
            x     = 8'($urandom);
            tick();
            exp = {m_y, 3'(m_s), m_b, (m_mode != 0), 2'(m_mode)};
            vectors++;
            if ({y, s, b, active, regime} !== exp) begin
                miscompares++;
                $display("FAIL random%0d: got y=%h s=%0d b=%b act=%b reg=%b, want y=%h s=%0d b=%b act=%b reg=%b",
                         n, y, s, b, active, regime, exp[14:7], exp[6:4], exp[3], exp[2], exp[1:0]);
            end
        end
        rst = 1'b0; start = 1'b0; on = 2'b00;
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift();
        test_rotate();
        test_abort_held_start();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
